// File: rtl/int_div_seq_pkg.sv
// Shared encodings and constants for the iterative RISC-V M-extension divider.
// Imported by the divider interface, the top level and the testbench.
package int_div_seq_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam int          ITER    = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic div0;
    logic ovf;
    logic neg_q;
    logic neg_r;
  } div_flags_t;

  // DIV and REM are the signed encodings (op[0] clear)
  function automatic logic op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/int_div_seq_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface int_div_seq_if #(parameter int TAG_W = 5);
  import int_div_seq_pkg::*;

  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [TAG_W-1:0] tag_in;
  logic             busy;
  logic             ready;
  logic [31:0]      result;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output start, flush, op, a, b, tag_in,
    input  busy, ready, result, tag_out
  );

  modport slave (
    input  start, flush, op, a, b, tag_in,
    output busy, ready, result, tag_out
  );

endinterface

// File: rtl/int_div_seq_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained on group carries.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        co
);

  logic [31:0] g_s;
  logic [31:0] p_s;
  logic [31:0] c_s;
  logic        carry_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // per-group lookahead of bit carries, group carry passed to the next group
  always_comb begin
    c_s     = 32'd0;
    carry_s = ci;
    for (int gi = 0; gi < 8; gi++) begin
      c_s[4*gi]   = carry_s;
      c_s[4*gi+1] = g_s[4*gi] | (p_s[4*gi] & carry_s);
      c_s[4*gi+2] = g_s[4*gi+1] | (p_s[4*gi+1] & g_s[4*gi])
                  | (p_s[4*gi+1] & p_s[4*gi] & carry_s);
      c_s[4*gi+3] = g_s[4*gi+2] | (p_s[4*gi+2] & g_s[4*gi+1])
                  | (p_s[4*gi+2] & p_s[4*gi+1] & g_s[4*gi])
                  | (p_s[4*gi+2] & p_s[4*gi+1] & p_s[4*gi] & carry_s);
      carry_s     = g_s[4*gi+3] | (p_s[4*gi+3] & g_s[4*gi+2])
                  | (p_s[4*gi+3] & p_s[4*gi+2] & g_s[4*gi+1])
                  | (p_s[4*gi+3] & p_s[4*gi+2] & p_s[4*gi+1] & g_s[4*gi])
                  | ((&p_s[4*gi +: 4]) & carry_s);
    end
  end

  assign sum = p_s ^ c_s;
  assign co  = carry_s;

endmodule

// File: rtl/int_div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one trial subtraction per
// cycle on cla32, a sign fix-up cycle, fixed 34-cycle latency, flushable.
module int_div_seq
  import int_div_seq_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  int_div_seq_if.slave bus
);

  logic [1:0]       state_r;
  logic [4:0]       count_r;
  logic [1:0]       op_r;
  logic [TAG_W-1:0] tag_lat_r;
  logic [TAG_W-1:0] tag_out_r;
  logic [31:0]      a_raw_r;
  logic [31:0]      b_abs_r;
  logic [31:0]      quo_r;
  logic [31:0]      rem_r;
  logic [31:0]      result_r;
  div_flags_t       flags_r;
  logic             busy_r;
  logic             ready_r;

  logic [32:0]      shifted_s;
  logic [31:0]      add_a_s, add_b_s, sum_a_s;
  logic [31:0]      neg_in_s, sum_b_s;
  logic [31:0]      a_abs_s, b_abs_s;
  logic [31:0]      q_fix_s, r_fix_s, res_fix_s;
  logic             add_ci_s, co_a_s, co_unused_s;
  logic             no_borrow_s, signed_op_s, accept_s;
  div_flags_t       flags_s;

  // the partial remainder stays below |b|, so only the shifted value needs 33 bits
  assign shifted_s   = {rem_r, quo_r[31]};
  assign no_borrow_s = shifted_s[32] | co_a_s;

  // shared adder: -b at start, trial subtraction in DIV, -quotient in FIX
  always_comb begin
    case (state_r)
      ST_IDLE: begin
        add_a_s  = ~bus.b;
        add_b_s  = 32'd0;
        add_ci_s = 1'b1;
      end
      ST_DIV: begin
        add_a_s  = shifted_s[31:0];
        add_b_s  = ~b_abs_r;
        add_ci_s = 1'b1;
      end
      ST_FIX: begin
        add_a_s  = ~quo_r;
        add_b_s  = 32'd0;
        add_ci_s = 1'b1;
      end
      default: begin
        add_a_s  = 32'd0;
        add_b_s  = 32'd0;
        add_ci_s = 1'b0;
      end
    endcase
  end

  cla32 u_cla_main (
    .a   (add_a_s),
    .b   (add_b_s),
    .ci  (add_ci_s),
    .sum (sum_a_s),
    .co  (co_a_s)
  );

  assign neg_in_s = (state_r == ST_IDLE) ? bus.a : rem_r;

  cla32 u_cla_neg (
    .a   (~neg_in_s),
    .b   (32'd0),
    .ci  (1'b1),
    .sum (sum_b_s),
    .co  (co_unused_s)
  );

  // operand magnitudes and special-case flags captured at the start edge
  always_comb begin
    signed_op_s = op_signed(bus.op);
    if (signed_op_s && bus.a[31]) begin
      a_abs_s = sum_b_s;
    end else begin
      a_abs_s = bus.a;
    end
    if (signed_op_s && bus.b[31]) begin
      b_abs_s = sum_a_s;
    end else begin
      b_abs_s = bus.b;
    end
    flags_s.div0  = (bus.b == 32'd0);
    flags_s.ovf   = signed_op_s && (bus.a == INT_MIN) && (bus.b == 32'hFFFF_FFFF);
    flags_s.neg_q = signed_op_s && (bus.a[31] ^ bus.b[31]);
    flags_s.neg_r = signed_op_s && bus.a[31];
  end

  // sign restoration, then div-by-zero and overflow overrides
  always_comb begin
    q_fix_s = flags_r.neg_q ? sum_a_s : quo_r;
    r_fix_s = flags_r.neg_r ? sum_b_s : rem_r;
    if (flags_r.div0) begin
      q_fix_s = 32'hFFFF_FFFF;
      r_fix_s = a_raw_r;
    end else if (flags_r.ovf) begin
      q_fix_s = INT_MIN;
      r_fix_s = 32'd0;
    end else begin
      q_fix_s = q_fix_s;
      r_fix_s = r_fix_s;
    end
    res_fix_s = op_r[1] ? r_fix_s : q_fix_s;
  end

  // ready is high in the first IDLE cycle; a start seen then is dropped
  assign accept_s = (state_r == ST_IDLE) && bus.start && !bus.flush && !ready_r;

  // control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= 5'd0;
      op_r      <= 2'd0;
      tag_lat_r <= '0;
      tag_out_r <= '0;
      a_raw_r   <= 32'd0;
      b_abs_r   <= 32'd0;
      quo_r     <= 32'd0;
      rem_r     <= 32'd0;
      result_r  <= 32'd0;
      flags_r   <= '0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b0;
          if (accept_s) begin
            op_r      <= bus.op;
            tag_lat_r <= bus.tag_in;
            a_raw_r   <= bus.a;
            b_abs_r   <= b_abs_s;
            quo_r     <= a_abs_s;
            rem_r     <= 32'd0;
            flags_r   <= flags_s;
            count_r   <= 5'd0;
            busy_r    <= 1'b1;
            state_r   <= ST_DIV;
          end
        end
        ST_DIV: begin
          ready_r <= 1'b0;
          if (bus.flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            quo_r   <= {quo_r[30:0], no_borrow_s};
            rem_r   <= no_borrow_s ? sum_a_s : shifted_s[31:0];
            count_r <= count_r + 5'd1;
            if (count_r == 5'(ITER - 1)) begin
              state_r <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
          if (bus.flush) begin
            ready_r <= 1'b0;
          end else begin
            result_r  <= res_fix_s;
            tag_out_r <= tag_lat_r;
            ready_r   <= 1'b1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.ready   = ready_r;
  assign bus.result  = result_r;
  assign bus.tag_out = tag_out_r;

endmodule

// File: tb/tb_int_div_seq.sv
// Scoreboard bench for int_div_seq: directed boundary cases plus random ops
// checked against an arithmetic reference model.
module tb_int_div_seq;
  import int_div_seq_pkg::*;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst;

  int_div_seq_if #(.TAG_W(TAG_W)) dif();

  int_div_seq #(.TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // RISC-V M-extension semantics in 64-bit arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  return (b == 32'd0) ? a : 32'(sa % sb);
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // monitor: every ready pulse must match the oldest outstanding operation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && dif.ready) begin
      if (sb_q.size() == 0) begin
        check32("ready_without_op", {31'd0, dif.ready}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check32("result", dif.result, e.res);
        check32("tag_out", {27'd0, dif.tag_out}, {27'd0, e.tag});
        check32("latency", 32'(cyc - e.cyc), 32'd33);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input bit expect_result);
    exp_t e;
    @(negedge clk);
    dif.op = op; dif.a = a; dif.b = b; dif.tag_in = tag; dif.start = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    if (expect_result) begin
      e.res = model(op, a, b); e.tag = tag; e.cyc = cyc;
      sb_q.push_back(e);
    end
    check32("busy_after_start", {31'd0, dif.busy}, 32'd1);
    dif.a = $urandom; dif.b = $urandom; dif.op = 2'($urandom); dif.tag_in = TAG_W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check32("ready_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [TAG_W-1:0] tag);
    issue(op, a, b, tag, 1'b1);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev, ra, rb;
    logic [1:0]  rop;
    bit          seen;

    rst = 1'b1;
    dif.start = 1'b0; dif.flush = 1'b0; dif.op = 2'd0;
    dif.a = 32'd0; dif.b = 32'd0; dif.tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_busy", {31'd0, dif.busy}, 32'd0);
    check32("rst_ready", {31'd0, dif.ready}, 32'd0);
    check32("rst_result", dif.result, 32'd0);
    check32("rst_tag", {27'd0, dif.tag_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(OP_DIVU, 32'd100, 32'd7, 5'd1);
    run(OP_REMU, 32'd100, 32'd7, 5'd2);
    run(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd3);
    run(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd4);
    run(OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run(OP_DIV,  32'h1234_5678, 32'd0, 5'd6);
    run(OP_REM,  32'h1234_5678, 32'd0, 5'd7);
    run(OP_DIV,  INT_MIN, 32'hFFFF_FFFF, 5'd8);
    run(OP_REM,  INT_MIN, 32'hFFFF_FFFF, 5'd9);
    run(OP_DIVU, INT_MIN, 32'hFFFF_FFFF, 5'd10);

    // flush during cycle 10 of an operation, restart in cycle 11
    prev = dif.result;
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd11, 1'b0);
    repeat (11) @(negedge clk);
    check32("busy_before_flush", {31'd0, dif.busy}, 32'd1);
    dif.flush = 1'b1;
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    check32("busy_after_flush", {31'd0, dif.busy}, 32'd0);
    check32("result_after_flush", dif.result, prev);
    run(OP_DIVU, 32'd1000, 32'd3, 5'd12);

    // flush and start together in IDLE: nothing starts
    @(negedge clk);
    dif.start = 1'b1; dif.flush = 1'b1; dif.b = 32'd5;
    @(posedge clk);
    #1;
    dif.start = 1'b0; dif.flush = 1'b0;
    check32("flush_beats_start", {31'd0, dif.busy}, 32'd0);
    repeat (40) @(negedge clk);

    // start in the ready cycle is ignored
    issue(OP_DIV, 32'hFFFF_FF00, 32'd16, 5'd13, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = dif.ready;
    end
    if (!seen) check32("ready_seen", {31'd0, dif.ready}, 32'd1);
    dif.start = 1'b1; dif.op = OP_DIVU; dif.a = 32'd9; dif.b = 32'd3;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    check32("start_in_ready_ignored", {31'd0, dif.busy}, 32'd0);
    wait_done();
    repeat (40) @(negedge clk);

    // second start while busy is ignored; first result comes back
    issue(OP_DIVU, 32'd5000, 32'd13, 5'd14, 1'b1);
    repeat (4) @(negedge clk);
    dif.start = 1'b1; dif.op = OP_REMU; dif.a = 32'd77; dif.b = 32'd10; dif.tag_in = 5'd30;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_done();

    // asynchronous reset mid-operation clears outputs at once
    issue(OP_REM, 32'd123456, 32'd789, 5'd15, 1'b0);
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check32("async_rst_busy", {31'd0, dif.busy}, 32'd0);
    check32("async_rst_ready", {31'd0, dif.ready}, 32'd0);
    check32("async_rst_result", dif.result, 32'd0);
    check32("async_rst_tag", {27'd0, dif.tag_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check32("idle_after_rst", {31'd0, dif.busy}, 32'd0);

    // randomized operations with a bias toward the special operand values
    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        3:       begin ra = INT_MIN; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      run(rop, ra, rb, TAG_W'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/int_div_seq.md
Name: int_div_seq

Overview:
- Iterative 32-bit integer divider for the RISC-V M-extension ops DIV, DIVU, REM and REMU.
- Sits beside the EX stage. The pipeline stalls on busy and writes back on ready.
- Each iteration does one trial subtraction on the team's 32-bit carry-lookahead adder (cla32).
- Honours flush so that an interrupt or branch can abort an in-flight divide.

Parameters:
- TAG_W, 5: width of the destination-register tag carried through with the operation.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin an operation; sampled only in IDLE
- flush  input  1  abort the operation in flight; return to IDLE
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- a  input  32  dividend
- b  input  32  divisor
- tag_in  input  TAG_W  destination tag, latched with start
- busy  output  1  high while an operation is in flight
- ready  output  1  one-cycle pulse; result and tag_out valid in that cycle
- result  output  32  quotient or remainder, selected by op
- tag_out  output  TAG_W  latched tag_in

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE, busy = 0, ready = 0, result = 0, tag_out = 0, count = 0.
- States: IDLE -> DIV -> FIX -> IDLE.
- IDLE:
  - On start=1 at a clock edge:
    - latch op and tag_in.
    - latch |a| and |b| for signed ops (raw values for unsigned).
    - record the sign of the quotient (a[31]^b[31]) and of the remainder (a[31]), signed ops only.
    - record the flags div0 (b==0) and ovf (DIV/REM with a==0x80000000 and b==0xFFFFFFFF).
    - clear the 33-bit partial remainder; count = 0; go to DIV.
  - busy = 1 from the cycle after the start edge.
- DIV (restoring), exactly 32 cycles:
  - Shift {rem, quo} left by 1.
  - trial = shifted rem − {0, |b|}, computed with cla32 (a = rem low bits, b = ~|b|, ci = 1); the 33rd bit gives the borrow.
  - No borrow: rem = trial, quo[0] = 1. Borrow: rem unchanged, quo[0] = 0.
  - count increments; leave for FIX when count == 31.
- FIX, one cycle:
  - Negate quo if the quotient sign is set; negate rem if the remainder sign is set.
  - Negation is ~x+1, done on the same cla32 instance (muxed operands) or on a second instance.
  - Special-case overrides, in priority order:
    - div0: quotient = 0xFFFFFFFF, remainder = a as latched before abs.
    - ovf: quotient = 0x80000000, remainder = 0.
  - Register result (quotient for ops 00/01, remainder for 10/11) and tag_out.
  - ready = 1 for this one cycle; busy = 0 at the next edge; state = IDLE.
- Latency:
  - start sampled at edge k gives ready high in the cycle after edge k+33.
  - Latency is fixed; special cases do not shorten it.
- result and tag_out hold their value after ready until the next FIX or reset.
- Boundary conditions:
  - start while busy: ignored; no queueing.
  - start in the same cycle as ready: ignored. FIX is not IDLE, so a new operation needs start one cycle later.
  - flush in DIV or FIX: state = IDLE and busy = 0 at the next edge, no ready pulse, result unchanged.
  - flush and start together in IDLE: flush wins; no operation starts.
  - flush in IDLE: no effect.
- Operands are sampled only at the start edge; later changes on a and b are ignored.

Decomposition:
- Shared package holds:
  - op encodings: OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11.
  - state encoding: IDLE, DIV, FIX.
  - constants: ITER = 32, INT_MIN = 32'h80000000.
- Sub-module: instantiate the existing cla32 adder for the trial subtraction and the sign fix-up.
- No new sub-module.

Test Plan:
- DIVU a=100, b=7, start at edge 0 -> busy high from cycle 1; ready pulse in cycle 34 with result=14; REMU gives 2.
- DIV a=−7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFD (−3); REM gives 0xFFFFFFFF (−1); REMU a=0xFFFFFFF9, b=2 gives 1.
- DIV a=0x12345678, b=0 -> 0xFFFFFFFF; REM b=0 -> 0x12345678; both at full latency.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU on the same operands -> 0.
- Start an op, then assert flush at cycle 10 -> busy=0 at cycle 11, no ready pulse, result holds its previous value; a new start at cycle 12 completes normally.
- Start an op, then start again at cycle 5 with different operands -> second start ignored; the first result is returned. Assert rst at cycle 20 -> all outputs 0 immediately, no ready pulse.
